// File: rtl/window_feed_ctrl_pkg.sv
// Shared types for the sliding-window feed sequencer: pixel type, FSM states
// and the stride limit that sizes the phase counters.
package sys_types;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH,
    ST_DONE
  } winfeed_state_t;

  localparam int WINFEED_MAX_STRIDE = 3;
  localparam int WINFEED_PH_W       = $clog2(WINFEED_MAX_STRIDE + 1);

  typedef logic [WINFEED_PH_W-1:0] stride_t;

  // A stride of 0 behaves as 1.
  function automatic stride_t eff_stride(input logic [1:0] s);
    return (s == 2'd0) ? stride_t'(1) : stride_t'(s);
  endfunction

endpackage

// File: rtl/window_feed_ctrl_if.sv
// SRAM read port plus the pixel/window handshake between the feed sequencer
// and the window generator / systolic input stage.
interface window_feed_ctrl_if #(
  parameter int ADDR_W = 16
);
  import sys_types::*;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  int8_t             mem_rdata;
  logic              pix_valid;
  int8_t             pix_data;
  logic              win_valid;
  logic              win_ready;
  logic              win_take;
  logic              win_clr;

  modport master (
    output mem_en, mem_addr, pix_valid, pix_data, win_take, win_clr,
    input  mem_rdata, win_valid, win_ready
  );

  modport slave (
    input  mem_en, mem_addr, pix_valid, pix_data, win_take, win_clr,
    output mem_rdata, win_valid, win_ready
  );

endinterface

// File: rtl/window_stride_gate.sv
// Qualifies generator windows by output stride: detects fires, tracks the
// window position (wc, wr) and the column/row phase counters.
module window_stride_gate
  import sys_types::*;
#(
  parameter int IMG_W = 96,
  parameter int IMG_H = 96
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    push,
  input  logic    win_valid,
  input  stride_t stride,
  output logic    win_take
);

  localparam int WC_W = $clog2(IMG_W);
  localparam int WR_W = $clog2(IMG_H);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(IMG_W - 4);
  localparam logic [WR_W-1:0] WR_LAST = WR_W'(IMG_H - 4);

  logic            push_reg;
  logic [WC_W-1:0] wc_reg;
  logic [WR_W-1:0] wr_reg;
  stride_t         cph_reg;
  stride_t         rph_reg;
  stride_t         ph_last;
  logic            fire;

  assign ph_last  = stride - stride_t'(1);
  assign fire     = push_reg && win_valid;
  assign win_take = fire && (cph_reg == '0) && (rph_reg == '0);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      push_reg <= 1'b0;
      wc_reg   <= '0;
      wr_reg   <= '0;
      cph_reg  <= '0;
      rph_reg  <= '0;
    end else begin
      push_reg <= push;
      if (fire) begin
        // Column phase restarts on every row so each row selects the same columns.
        if (wc_reg == WC_LAST) begin
          wc_reg  <= '0;
          cph_reg <= '0;
          rph_reg <= (rph_reg == ph_last) ? '0 : rph_reg + 1'b1;
          wr_reg  <= (wr_reg == WR_LAST) ? '0 : wr_reg + 1'b1;
        end else begin
          wc_reg  <= wc_reg + 1'b1;
          cph_reg <= (cph_reg == ph_last) ? '0 : cph_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/window_feed_ctrl.sv
// Frame sequencer feeding the 4x4 window generator from activation SRAM.
// Define WINFEED_PERF_EN to add the stall_cnt / win_cnt performance counters.
module window_feed_ctrl
  import sys_types::*;
#(
  parameter int IMG_W  = 96,
  parameter int IMG_H  = 96,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        stride,
  output logic              busy,
  output logic              done,
  window_feed_ctrl_if.master bus
`ifdef WINFEED_PERF_EN
  , output logic [31:0]     stall_cnt
  , output logic [31:0]     win_cnt
`endif
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0] PIX_N    = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NPIX - 1);

  winfeed_state_t    state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  stride_t           stride_reg;
  logic [CNT_W-1:0]  rd_cnt_reg;
  logic [CNT_W-1:0]  push_cnt_reg;
  logic [1:0]        flush_cnt_reg;
  logic              pend_reg;
  logic              hold_full_reg;
  int8_t             hold_reg;

  logic  mem_en;
  logic  pix_valid;
  int8_t pix_data;
  logic  win_take;
  logic  win_clr;
  logic  frame_start;

  assign frame_start = (state_reg == ST_IDLE) && start;

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    win_clr    = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_en = bus.win_ready && !hold_full_reg && (rd_cnt_reg != PIX_N);
        if (bus.win_ready && (pend_reg || hold_full_reg)) begin
          pix_valid = 1'b1;
          pix_data  = hold_full_reg ? hold_reg : bus.mem_rdata;
          if (push_cnt_reg == PIX_LAST) state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // One idle cycle after the third flush push lets the last window fire before the clear.
        if (flush_cnt_reg == 2'd3) state_next = ST_DONE;
        else                       pix_valid  = bus.win_ready;
      end
      ST_DONE: begin
        win_clr    = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      stride_reg    <= stride_t'(1);
      rd_cnt_reg    <= '0;
      push_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      pend_reg      <= 1'b0;
      hold_full_reg <= 1'b0;
      hold_reg      <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= mem_en;
      if (frame_start) begin
        base_reg      <= base_addr;
        stride_reg    <= eff_stride(stride);
        rd_cnt_reg    <= '0;
        push_cnt_reg  <= '0;
        flush_cnt_reg <= '0;
        hold_full_reg <= 1'b0;
      end
      if (mem_en) rd_cnt_reg <= rd_cnt_reg + 1'b1;
      if (pix_valid && state_reg == ST_FETCH) push_cnt_reg <= push_cnt_reg + 1'b1;
      if (pix_valid && state_reg == ST_FLUSH) flush_cnt_reg <= flush_cnt_reg + 1'b1;
      if (state_reg == ST_FETCH) begin
        if (pend_reg && !bus.win_ready) begin
          hold_full_reg <= 1'b1;
          hold_reg      <= bus.mem_rdata;
        end else if (hold_full_reg && bus.win_ready) begin
          hold_full_reg <= 1'b0;
        end
      end
    end
  end

  window_stride_gate #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_gate (
    .clk       (clk),
    .reset     (reset),
    .clr       (frame_start),
    .push      (pix_valid),
    .win_valid (bus.win_valid),
    .stride    (stride_reg),
    .win_take  (win_take)
  );

  assign busy          = (state_reg != ST_IDLE);
  assign bus.mem_en    = mem_en;
  assign bus.mem_addr  = mem_en ? base_reg + ADDR_W'(rd_cnt_reg) : '0;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_data  = pix_data;
  assign bus.win_take  = win_take;
  assign bus.win_clr   = win_clr;

`ifdef WINFEED_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] win_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      stall_cnt_reg <= '0;
      win_cnt_reg   <= '0;
    end else begin
      if ((state_reg == ST_FETCH || state_reg == ST_FLUSH) && !bus.win_ready &&
          stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (win_take && win_cnt_reg != '1)
        win_cnt_reg <= win_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign win_cnt   = win_cnt_reg;
`endif

endmodule

// File: doc/window_feed_ctrl.md
# window_feed_ctrl

Sequencer for the 4x4 sliding-window generator. It streams one image frame, row-major, from a single-port activation SRAM into the generator's pixel port, applies output stride by qualifying the windows the generator emits, and pushes three flush pixels at end of frame so the last windows drain. It also respects downstream backpressure from the systolic-array input stage and clears the generator between frames.

## Interface
Parameters:
- IMG_W, 96, frame width in pixels (≥4)
- IMG_H, 96, frame height in pixels (≥4)
- ADDR_W, 16, SRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- base_addr  in  ADDR_W  address of pixel (0,0); latched on start
- stride  in  2  output stride, 1..3; latched on start; 0 treated as 1
- mem_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  8  int8_t read data, valid the cycle after mem_en
- pix_valid  out  1  drives generator valid_in (push)
- pix_data  out  8  int8_t, drives generator pixel_in
- win_valid  in  1  generator valid_out
- win_ready  in  1  downstream can take one window in the next cycle
- win_take  out  1  current generator window is stride-selected; downstream must latch A0..A3
- win_clr  out  1  one-cycle clear; integration ORs it into generator reset
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, frame complete

## Operation
- FSM states: IDLE → FETCH → FLUSH → DONE → IDLE.
- IDLE: all outputs 0. On start: latch base_addr and stride, zero the counters, go to FETCH.
- FETCH issues reads for pixel index p = 0..IMG_W*IMG_H−1.
  - mem_addr = base_addr + p, modulo 2^ADDR_W.
  - A read issues when win_ready=1 and the hold register is empty.
  - Returned data is pushed when win_ready=1 in the return cycle. Otherwise it is captured in a 1-entry hold register and pushed on the first later cycle with win_ready=1. No read issues while hold is full.
  - After the last pixel is pushed, go to FLUSH.
- FLUSH: push three pixels of value 0, each gated by win_ready. After the third push, go to DONE.
- DONE: win_clr=1 and done=1 for one cycle, then go to IDLE.
- Window qualification:
  - fire = (push occurred previous cycle) AND win_valid.
  - Window counters wc (0..IMG_W−4) and wr (0..IMG_H−4) advance on each fire, row-major.
  - Phase counters cph/rph count 0..stride−1. rph advances only when wc wraps.
  - win_take = fire AND cph==0 AND rph==0.
- Expected fires per frame: (IMG_W−3)*(IMG_H−3), e.g. 8649 at 96x96.
- start asserted outside IDLE is ignored.
- Reset mid-frame: return to IDLE immediately, drop the hold register and any in-flight read, all outputs 0. The generator's own reset clears it.

## Timing
- Reset values: mem_en, mem_addr, pix_valid, pix_data, win_take, win_clr, busy, done all 0.
- start in cycle t with win_ready held 1:
  - first mem_en at t+1
  - first pix_valid at t+2
  - one pixel pushed per cycle thereafter
- Frame duration with no stalls: done at t + IMG_W*IMG_H + 6 (1 FSM entry + 1 SRAM latency + pushes + 3 flush + DONE).
- win_ready low in cycle t blocks issue and push in cycle t. It never loses a pixel, and at most one pixel is ever held.
- win_take is combinational from registered state plus win_valid, one cycle after the enabling push. The downstream stage guarantees a slot because win_ready was high at that push.
- busy rises the cycle after start and falls with done.

## Configuration
- WINFEED_PERF_EN defined:
  - adds outputs stall_cnt (32, cycles in FETCH/FLUSH with win_ready=0) and win_cnt (32, win_take count)
  - both cleared on start; both saturate at all-ones
- Undefined: both ports and their counters are absent. Functional behaviour is identical.

## Structure
- Shared package (sys_types): int8_t; the FSM state enum winfeed_state_t; the stride limit constant WINFEED_MAX_STRIDE=3.
- One sub-module: window_stride_gate, containing fire detection, wc/wr and phase counters, and win_take.
- The top level holds the FSM, address generation and the hold register.

## Test plan
- 8x8 frame, stride 1, win_ready=1, pixel value = index:
  - exactly 25 win_take
  - 67 pushes (64 + 3 flush)
  - done at t+70
  - first window A0 row = {24,25,26,27}
- 8x8 frame, stride 2: win_take only at (wr,wc) ∈ {0,2,4}², 9 total.
- Toggle win_ready 1-0 every cycle:
  - pixel order intact
  - no pixel read twice
  - hold register exercised
  - window contents match the stride-1 run
- base_addr = 0xFFF0 with ADDR_W=16: addresses wrap to 0x0000 after 0xFFFF.
- Reset asserted mid-FETCH, then a new start:
  - outputs 0 the cycle after reset
  - the second frame produces the full 25 windows
- start asserted while busy: ignored, frame count and done pulses unaffected.
